// File: rtl/axis_arb_pkg.sv
// Shared types and width helpers for the AXI4-Stream round-robin arbiter.
// Optional feature macro: AXIS_ARB_ID_EN (source-index sideband on the output).
package axis_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/axis_rr_picker.sv
// Rotating-priority picker: first set request after 'last', with wrap.
// Purely combinational; used by the arbiter's idle decision.
module axis_rr_picker
    import axis_arb_pkg::*;
#(
    parameter int N_PORTS = 4,
    parameter int GW      = clog2_min1(N_PORTS)
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [GW-1:0]      last,
    output logic               found,
    output logic [GW-1:0]      idx
);

    always_comb begin
        int p;
        found = 1'b0;
        idx   = '0;
        p     = 0;
        for (int i = 1; i <= N_PORTS; i++) begin
            p = (int'(last) + i) % N_PORTS;
            if (!found && req[p]) begin
                found = 1'b1;
                idx   = GW'(p);
            end
        end
    end

endmodule

// File: rtl/axis_rr_arbiter.sv
// N:1 round-robin AXI4-Stream arbiter with burst-limited grants and a
// registered output stage. Optional macro AXIS_ARB_ID_EN adds m_id.
module axis_rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter  int N_PORTS   = 4,
    parameter  int DATA_SIZE = 8,
    parameter  int BURST_LEN = 4,
    localparam int GW        = clog2_min1(N_PORTS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_PORTS*DATA_SIZE-1:0] s_data,
    input  logic [N_PORTS-1:0]           s_valid,
    output logic [N_PORTS-1:0]           s_ready,
    output logic [DATA_SIZE-1:0]         m_data,
    output logic                         m_valid,
    input  logic                         m_ready,
`ifdef AXIS_ARB_ID_EN
    output logic [GW-1:0]                m_id,
`endif
    output logic [GW-1:0]                grant
);

    localparam int            CW        = clog2_min1(BURST_LEN);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);
    localparam logic [GW-1:0] LAST_PORT = GW'(N_PORTS - 1);

    arb_state_e state, state_nxt;

    logic [GW-1:0]        grant_nxt;
    logic [GW-1:0]        last_grant, last_grant_nxt;
    logic [GW-1:0]        pick_idx;
    logic [CW-1:0]        beat_cnt, beat_cnt_nxt;
    logic                 pick_found;
    logic                 load_en;
    logic                 sel_valid;
    logic                 xfer;
    logic [DATA_SIZE-1:0] sel_data;

    axis_rr_picker #(
        .N_PORTS (N_PORTS),
        .GW      (GW)
    ) u_picker (
        .req   (s_valid),
        .last  (last_grant),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (grant == GW'(i)) begin
                sel_valid = s_valid[i];
                sel_data  = s_data[i*DATA_SIZE +: DATA_SIZE];
            end
        end
    end

    assign load_en = !m_valid || m_ready;
    assign xfer    = (state == ARB_GRANT) && sel_valid && load_en;

    // Only the granted port sees ready, and only when the output can load.
    always_comb begin
        s_ready = '0;
        if (state == ARB_GRANT) begin
            for (int i = 0; i < N_PORTS; i++) begin
                s_ready[i] = (grant == GW'(i)) && load_en;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        beat_cnt_nxt   = beat_cnt;
        unique case (state)
            ARB_IDLE: begin
                if (pick_found) begin
                    state_nxt    = ARB_GRANT;
                    grant_nxt    = pick_idx;
                    beat_cnt_nxt = '0;
                end
            end
            ARB_GRANT: begin
                if (xfer) begin
                    if (beat_cnt == LAST_BEAT) begin
                        state_nxt      = ARB_IDLE;
                        last_grant_nxt = grant;
                        beat_cnt_nxt   = '0;
                    end else begin
                        beat_cnt_nxt = beat_cnt + CW'(1);
                    end
                end else if (!sel_valid) begin
                    state_nxt      = ARB_IDLE;
                    last_grant_nxt = grant;
                end
            end
            default: begin
                state_nxt = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ARB_IDLE;
            grant      <= '0;
            last_grant <= LAST_PORT;
            beat_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
            beat_cnt   <= beat_cnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_data  <= '0;
`ifdef AXIS_ARB_ID_EN
            m_id    <= '0;
`endif
        end else if (xfer) begin
            m_valid <= 1'b1;
            m_data  <= sel_data;
`ifdef AXIS_ARB_ID_EN
            m_id    <= grant;
`endif
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Scoreboard bench for axis_rr_arbiter (N=4, 8-bit, burst 4).
// Checks m_id too when built with AXIS_ARB_ID_EN.
module tb_axis_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int BL = 4;
    localparam int GW = 2;

    typedef struct {
        logic [7:0] data;
        int         port;
    } beat_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [N*DW-1:0] s_data;
    logic [N-1:0]    s_valid;
    logic [N-1:0]    s_ready;
    logic [DW-1:0]   m_data;
    logic            m_valid;
    logic            m_ready;
    logic [GW-1:0]   grant;
`ifdef AXIS_ARB_ID_EN
    logic [GW-1:0]   m_id;
`endif

    beat_t      exp_q[$];
    logic [7:0] src_q[N][$];
    int         fire_cyc[$];
    int         fire_port[$];
    int         out_cyc[$];
    logic [N-1:0] en;
    logic       mr;
    int         cyc;
    int         checks   = 0;
    int         failures = 0;

    axis_rr_arbiter #(
        .N_PORTS   (N),
        .DATA_SIZE (DW),
        .BURST_LEN (BL)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
`ifdef AXIS_ARB_ID_EN
        .m_id    (m_id),
`endif
        .grant   (grant)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One cycle: drive at negedge, observe handshakes, score outputs.
    task automatic step();
        logic [N-1:0] fire;
        beat_t        e;
        @(negedge clk);
        m_ready = mr;
        for (int i = 0; i < N; i++) begin
            s_valid[i] = en[i] && (src_q[i].size() > 0);
            s_data[i*DW +: DW] = (src_q[i].size() > 0) ? src_q[i][0] : 8'h00;
        end
        #1;
        fire = s_valid & s_ready;
        chk("ready_onehot", 32'($countones(s_ready) <= 1), 32'd1);
        if (m_valid && m_ready) begin
            out_cyc.push_back(cyc);
            checks++;
            assert (exp_q.size() > 0) else begin
                failures++;
                $error("FAIL unexpected_beat got=%0h exp=none", m_data);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("m_data", 32'(m_data), 32'(e.data));
`ifdef AXIS_ARB_ID_EN
                chk("m_id", 32'(m_id), 32'(e.port));
`endif
            end
        end
        for (int i = 0; i < N; i++) begin
            if (fire[i]) begin
                fire_cyc.push_back(cyc);
                fire_port.push_back(i);
                void'(src_q[i].pop_front());
            end
        end
        cyc++;
    endtask

    task automatic clear_tb();
        en = '0;
        s_valid = '0;
        s_data = '0;
        for (int i = 0; i < N; i++) src_q[i].delete();
        exp_q.delete();
        fire_cyc.delete();
        fire_port.delete();
        out_cyc.delete();
        cyc = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        clear_tb();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        cyc = 0;
    endtask

    // Sources with continuous valid; expected order from a burst-level RR model.
    task automatic load(input logic [7:0] base, input int c0, input int c1,
                        input int c2, input int c3);
        int left[N];
        int sent[N];
        int last;
        int p;
        int n;
        beat_t b;
        left[0] = c0; left[1] = c1; left[2] = c2; left[3] = c3;
        for (int i = 0; i < N; i++) begin
            sent[i] = 0;
            for (int k = 0; k < left[i]; k++)
                src_q[i].push_back(8'(int'(base) + i*16 + k));
        end
        last = N - 1;
        while (left[0] + left[1] + left[2] + left[3] > 0) begin
            p = -1;
            for (int o = 1; o <= N; o++) begin
                if (p < 0 && left[(last + o) % N] > 0) p = (last + o) % N;
            end
            n = (left[p] < BL) ? left[p] : BL;
            for (int k = 0; k < n; k++) begin
                b.data = 8'(int'(base) + p*16 + sent[p] + k);
                b.port = p;
                exp_q.push_back(b);
            end
            left[p] -= n;
            sent[p] += n;
            last = p;
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            step();
            n++;
        end
        checks++;
        assert (exp_q.size() == 0) else begin
            failures++;
            $error("FAIL drain_timeout got=%0d exp=0", exp_q.size());
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input int p);
        beat_t b;
        b.data = d;
        b.port = p;
        exp_q.push_back(b);
    endtask

    initial begin
        reset = 1'b1;
        mr = 1'b1;
        m_ready = 1'b1;
        clear_tb();
        #12;
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);

        // Single requester: port 2, 0x10..0x17
        do_reset();
        load(8'hF0, 0, 0, 8, 0);
        en = 4'b0100;
        drain(40);
        chk("single_nfire", fire_cyc.size(), 8);
        chk("single_first_ready", fire_cyc[0], 1);
        chk("single_first_out", out_cyc[0], 2);
        chk("single_burst_end", fire_cyc[3], 4);
        chk("single_regrant", fire_cyc[4], 6);
        chk("single_last", fire_cyc[7], 9);
        for (int k = 0; k < 8; k++) chk("single_port", fire_port[k], 2);
        chk("single_grant", 32'(grant), 32'd2);

        // All four ports, continuous valid
        do_reset();
        load(8'h40, 8, 8, 8, 8);
        en = 4'hF;
        drain(100);
        chk("all_nfire", fire_cyc.size(), 32);
        for (int k = 0; k < 32; k++) begin
            chk("all_cyc", fire_cyc[k], 1 + 5*(k/4) + (k%4));
            chk("all_port", fire_port[k], (k/4) % 4);
        end

        // Backpressure during a port 0 burst
        do_reset();
        load(8'h20, 5, 0, 0, 0);
        en = 4'b0001;
        repeat (3) step();
        mr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_s_ready", 32'(s_ready), 32'd0);
            chk("bp_m_valid", 32'(m_valid), 32'd1);
            chk("bp_m_data", 32'(m_data), 32'h21);
        end
        mr = 1'b1;
        drain(30);
        chk("bp_nfire", fire_cyc.size(), 5);
        chk("bp_resume", fire_cyc[2], 6);
        chk("bp_release", fire_cyc[3], 7);
        chk("bp_regrant", fire_cyc[4], 9);

        // Early release by port 3 while port 1 waits
        do_reset();
        src_q[3].push_back(8'h30);
        src_q[3].push_back(8'h31);
        for (int k = 0; k < 4; k++) src_q[1].push_back(8'(8'h50 + k));
        push_exp(8'h30, 3);
        push_exp(8'h31, 3);
        for (int k = 0; k < 4; k++) push_exp(8'(8'h50 + k), 1);
        en = 4'b1000;
        step();
        en = 4'b1010;
        drain(30);
        chk("early_nfire", fire_cyc.size(), 6);
        chk("early_first_port", fire_port[0], 3);
        chk("early_next_port", fire_port[2], 1);
        chk("early_next_cyc", fire_cyc[2], 5);
        chk("early_grant", 32'(grant), 32'd1);

        // Reset mid-burst on port 1
        do_reset();
        for (int k = 0; k < 8; k++) src_q[1].push_back(8'(8'h60 + k));
        push_exp(8'h60, 1);
        en = 4'b0010;
        repeat (3) step();
        reset = 1'b1;
        #1;
        chk("mid_rst_m_valid", 32'(m_valid), 32'd0);
        chk("mid_rst_s_ready", 32'(s_ready), 32'd0);
        chk("mid_rst_grant", 32'(grant), 32'd0);
        chk("mid_rst_scored", exp_q.size(), 0);
        do_reset();
        load(8'h80, 1, 1, 1, 1);
        en = 4'hF;
        drain(40);
        chk("post_rst_nfire", fire_cyc.size(), 4);
        chk("post_rst_first_cyc", fire_cyc[0], 1);
        for (int k = 0; k < 4; k++) chk("post_rst_port", fire_port[k], k);

        // Interleaved ports 0 and 2 (also scores m_id when enabled)
        do_reset();
        load(8'h00, 6, 0, 6, 0);
        en = 4'b0101;
        drain(60);
        chk("id_nfire", fire_cyc.size(), 12);
        chk("id_port4", fire_port[4], 2);
        chk("id_port8", fire_port[8], 0);

        repeat (3) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axis_rr_arbiter.md
Name: axis_rr_arbiter

Overview:
- N:1 round-robin arbiter that shares one AXI4-Stream output (data/valid/ready, no tlast) between N_PORTS stream requesters.
- Grants one requester at a time, holds the grant for up to BURST_LEN beats, and drives a registered output stage.
- Sits in front of the skid buffer datapath, so several producers can feed one buffered stream.

Parameters:
- N_PORTS, 4, number of requesters; must be >= 2.
- DATA_SIZE, 8, data width per stream, in bits.
- BURST_LEN, 4, maximum beats per grant before forced re-arbitration; must be >= 1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- s_data  input  N_PORTS*DATA_SIZE  requester data; port i occupies bits [i*DATA_SIZE +: DATA_SIZE].
- s_valid  input  N_PORTS  requester valid, one bit per port.
- s_ready  output  N_PORTS  requester ready, one bit per port; at most one bit high in any cycle.
- m_data  output  DATA_SIZE  arbitrated output data, registered.
- m_valid  output  1  output valid, registered.
- m_ready  input  1  downstream ready.
- grant  output  GW  index of the current or last granted port; GW = max(1, $clog2(N_PORTS)).

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - m_valid=0, m_data=0, s_ready=0, grant=0.
  - state=ARB_IDLE, beat_cnt=0, last_grant=N_PORTS-1, so port 0 has first priority.
  - A beat held in the output register is discarded, even mid-burst.
- Output stage:
  - load_en = !m_valid || m_ready.
  - An input transfer on port i happens when s_valid[i] && s_ready[i]. It writes m_data and sets m_valid=1 on the next edge.
  - If m_ready=1 with no new load, m_valid clears.
  - Full throughput: one beat per cycle while a grant is held and the downstream is ready.
- ARB_IDLE:
  - s_ready all 0.
  - If any s_valid is high, pick the first set bit scanning (last_grant+1) mod N_PORTS upward with wrap. Register it into grant, set beat_cnt=0, go to ARB_GRANT.
  - If no s_valid is high, stay in ARB_IDLE.
- ARB_GRANT:
  - s_ready[grant] = load_en; all other s_ready bits are 0.
  - On a transfer: beat_cnt++.
  - If that transfer is beat BURST_LEN-1: go to ARB_IDLE, last_grant<=grant, beat_cnt<=0.
  - If s_valid[grant]=0: go to ARB_IDLE with last_grant<=grant and no transfer.
  - If load_en=0 (stalled): hold state, grant and beat_cnt.
- Latency:
  - s_valid rises at cycle 0 in ARB_IDLE → s_ready high at cycle 1 → m_valid at cycle 2, if downstream is ready.
  - Every grant switch costs exactly one idle cycle (the ARB_IDLE decision cycle).
- Boundary conditions:
  - BURST_LEN=1 means a strict per-beat round robin with one bubble between beats.
  - A sole active requester is re-granted after release. The scan wraps back to it.
  - grant keeps its value in ARB_IDLE until the next decision.
  - beat_cnt width is max(1, $clog2(BURST_LEN)).
  - Downstream stall at the final burst beat: the transfer only counts once it happens; release follows that transfer.

Optional Feature:
- Macro AXIS_ARB_ID_EN.
- When defined: an extra output m_id [GW] is registered alongside m_data. It carries the source port index of the beat in the output register, and resets to 0.
- When undefined: no m_id port and no extra register; everything else is identical.

Decomposition:
- Package axis_arb_pkg:
  - arb_state_e enum {ARB_IDLE, ARB_GRANT}.
  - Function clog2_min1 for GW and counter widths.
- Sub-module axis_rr_picker: purely combinational rotating-priority picker. Inputs are req[N_PORTS] and last[GW]; outputs are found and idx[GW]. It is instantiated once in ARB_IDLE decision logic.

Test Plan:
- Reset mid-burst: port 1 streaming, assert reset at beat 2 → m_valid=0, s_ready=0 on the same cycle. After release, port 0 is granted first when all ports request.
- Single requester: port 2 sends 0x10..0x17 with m_ready=1 and BURST_LEN=4 → output 0x10..0x13, one bubble, then 0x14..0x17. grant=2 throughout.
- All four ports valid continuously, BURST_LEN=4, m_ready=1 → 4 beats each in grant order 0,1,2,3,0, with exactly one idle cycle between bursts.
- Backpressure: m_ready low for 3 cycles during a port 0 burst → s_ready[0]=0 while the output register is full. m_data is held stable and no beat is lost or duplicated; beat_cnt resumes.
- Early release: port 3 drops s_valid after 2 beats while port 1 is waiting → ARB_IDLE, then port 1 is granted next (scan from 0 wraps to 1).
- AXIS_ARB_ID_EN defined: interleaved traffic from ports 0 and 2 → m_id equals the source index on every beat with m_valid=1.
